// File: rtl/pwm_generator.sv
// rtl/pwm_generator.sv - 16-pin PWM output stage with shared 8-bit counter and prescaler
// Optional macro PWM_SYNC_UPDATE_EN: shadow the duty value so writes take effect at period boundaries.
module pwm_generator #(
  parameter int PRESCALE = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] pwm_out,
  output logic        period_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;
  logic [7:0]    pwm_cnt;
  logic          tick;
  logic [7:0]    duty_eff;
  logic          pwm_sig;
  logic [15:0]   en_out;
  logic [15:0]   en_pwm;
  logic [15:0]   pin_nxt;

  // With PRESCALE = 1 pre_cnt never leaves 0, so tick is permanently high.
  assign tick = (pre_cnt == PRE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  assign period_start = (pwm_cnt == 8'd0) && (pre_cnt == '0);

`ifdef PWM_SYNC_UPDATE_EN
  logic [7:0] duty_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            duty_shadow <= 8'd0;
    else if (period_start) duty_shadow <= pwm_duty_cycle;
  end

  // Bypass lets the first clk of a period already use the freshly sampled duty.
  assign duty_eff = period_start ? pwm_duty_cycle : duty_shadow;
`else
  assign duty_eff = pwm_duty_cycle;
`endif

  assign pwm_sig = (duty_eff == 8'hFF) ? 1'b1 : (pwm_cnt < duty_eff);

  assign en_out  = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign pin_nxt = en_out & (~en_pwm | {16{pwm_sig}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_out <= 16'h0000;
    else        pwm_out <= pin_nxt;
  end

endmodule

// File: tb/tb_pwm_generator.sv
// tb/tb_pwm_generator.sv - scoreboard bench for pwm_generator (PRESCALE = 12)
module tb_pwm_generator;

  localparam int PRE    = 12;
  localparam int PERIOD = 256 * PRE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] en_out = 16'h0000;
  logic [15:0] en_pwm = 16'h0000;
  logic [7:0]  duty = 8'h00;
  logic [15:0] pwm_out;
  logic        period_start;

  int errors = 0;
  int checks = 0;
  int nprint = 0;
  int t = 0;
  logic [7:0]  m_shadow = 8'h00;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  pwm_generator #(.PRESCALE(PRE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .pwm_out         (pwm_out),
    .period_start    (period_start)
  );

  // One clk: predict the registered output from the count state before the edge, then compare after it.
  task automatic step();
    logic [7:0]  cnt;
    logic [7:0]  deff;
    logic        sig;
    logic [15:0] exp_out;
    cnt = 8'((t / PRE) % 256);
`ifdef PWM_SYNC_UPDATE_EN
    deff = (t % PERIOD == 0) ? duty : m_shadow;
    if (t % PERIOD == 0) m_shadow = duty;
`else
    deff = duty;
`endif
    sig = (deff == 8'hFF) ? 1'b1 : (cnt < deff);
    exp_q.push_back(en_out & (~en_pwm | {16{sig}}));
    @(posedge clk);
    #1;
    t++;
    exp_out = exp_q.pop_front();
    checks++;
    if (pwm_out !== exp_out) begin
      errors++;
      if (nprint < 20) $display("FAIL pwm_out t=%0d got %h expected %h", t, pwm_out, exp_out);
      nprint++;
    end
    checks++;
    if (period_start !== (t % PERIOD == 0)) begin
      errors++;
      if (nprint < 20) $display("FAIL period_start t=%0d got %b expected %b", t, period_start, (t % PERIOD == 0));
      nprint++;
    end
  endtask

  task automatic align();
    while (t % PERIOD != 0) step();
  endtask

  task automatic restart_model();
    t = 0;
    m_shadow = 8'h00;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en_out = 16'hFFFF; en_pwm = 16'h0000; duty = 8'h80;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pwm_out !== 16'h0000) begin errors++; $display("FAIL reset_out got %h expected 0000", pwm_out); end
    checks++;
    if (period_start !== 1'b1) begin errors++; $display("FAIL reset_ps got %b expected 1", period_start); end
    rst_n = 1'b1;
    restart_model();
    #1;
    checks++;
    if (pwm_out !== 16'h0000) begin errors++; $display("FAIL release_out got %h expected 0000", pwm_out); end
    step();
    checks++;
    if (pwm_out !== 16'hFFFF) begin errors++; $display("FAIL static_high got %h expected ffff", pwm_out); end
    repeat (10) step();
  endtask

  task automatic test_duty50();
    int hi;
    int ps;
    logic prev_ps;
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'd128;
    align();
    prev_ps = 1'b1;
    for (int p = 0; p < 2; p++) begin
      hi = 0; ps = 0;
      for (int i = 0; i < PERIOD; i++) begin
        step();
        if (pwm_out[0]) hi++;
        if (period_start) ps++;
        if (prev_ps) begin
          checks++;
          if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL rise_after_ps got %b expected 1", pwm_out[0]); end
        end
        prev_ps = period_start;
      end
      checks++;
      if (hi != 1536) begin errors++; $display("FAIL duty50_high got %0d expected 1536", hi); end
      checks++;
      if (ps != 1) begin errors++; $display("FAIL duty50_ps_count got %0d expected 1", ps); end
    end
  endtask

  task automatic test_extremes();
    int hi;
    en_out = 16'h0001; en_pwm = 16'h0001;
    duty = 8'd0;
    align();
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin step(); if (pwm_out[0]) hi++; end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL duty0_high got %0d expected 0", hi); end
    duty = 8'd255;
    hi = 0;
    for (int i = 0; i < PERIOD + 24; i++) begin step(); if (pwm_out[0]) hi++; end
    checks++;
    if (hi != PERIOD + 24) begin errors++; $display("FAIL duty255_high got %0d expected %0d", hi, PERIOD + 24); end
    duty = 8'd1;
    align();
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin step(); if (pwm_out[0]) hi++; end
    checks++;
    if (hi != 12) begin errors++; $display("FAIL duty1_high got %0d expected 12", hi); end
  endtask

  task automatic test_enable_priority();
    int toggles;
    logic [15:0] prev;
    en_out = 16'h00F0; en_pwm = 16'hFF00; duty = 8'd64;
    step();
    prev = pwm_out;
    toggles = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (pwm_out !== prev) toggles++;
      prev = pwm_out;
    end
    checks++;
    if (toggles != 0) begin errors++; $display("FAIL prio_toggles got %0d expected 0", toggles); end
    checks++;
    if (pwm_out !== 16'h00F0) begin errors++; $display("FAIL prio_value got %h expected 00f0", pwm_out); end
  endtask

  task automatic test_mid_write();
    int hi;
    int exp_hi;
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'd200;
    align();
    hi = 0;
    for (int i = 0; i < 50 * PRE; i++) begin step(); if (pwm_out[0]) hi++; end
    checks++;
    if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL mid_before got %b expected 1", pwm_out[0]); end
    duty = 8'd10;
    step();
    if (pwm_out[0]) hi++;
`ifdef PWM_SYNC_UPDATE_EN
    checks++;
    if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL mid_after got %b expected 1", pwm_out[0]); end
    exp_hi = 200 * PRE;
`else
    checks++;
    if (pwm_out[0] !== 1'b0) begin errors++; $display("FAIL mid_after got %b expected 0", pwm_out[0]); end
    exp_hi = 50 * PRE;
`endif
    for (int i = 50 * PRE + 1; i < PERIOD; i++) begin step(); if (pwm_out[0]) hi++; end
    checks++;
    if (hi != exp_hi) begin errors++; $display("FAIL mid_cur_high got %0d expected %0d", hi, exp_hi); end
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin step(); if (pwm_out[0]) hi++; end
    checks++;
    if (hi != 120) begin errors++; $display("FAIL mid_next_high got %0d expected 120", hi); end
  endtask

  task automatic test_reset_mid();
    int hi;
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'd128;
    align();
    repeat (100 * PRE) step();
    checks++;
    if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL pre_reset got %b expected 1", pwm_out[0]); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 16'h0000) begin errors++; $display("FAIL async_reset got %h expected 0000", pwm_out); end
    checks++;
    if (period_start !== 1'b1) begin errors++; $display("FAIL reset_mid_ps got %b expected 1", period_start); end
    @(posedge clk);
    #1;
    checks++;
    if (pwm_out !== 16'h0000) begin errors++; $display("FAIL held_reset got %h expected 0000", pwm_out); end
    rst_n = 1'b1;
    restart_model();
    #1;
    checks++;
    if (period_start !== 1'b1) begin errors++; $display("FAIL release_ps got %b expected 1", period_start); end
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      if (pwm_out[0]) hi++;
      if (i == 0) begin
        checks++;
        if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL restart_first got %b expected 1", pwm_out[0]); end
      end
    end
    checks++;
    if (hi != 1536) begin errors++; $display("FAIL restart_high got %0d expected 1536", hi); end
  endtask

  initial begin
    test_reset();
    test_duty50();
    test_extremes();
    test_enable_priority();
    test_mid_write();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Output stage that sits directly downstream of the SPI register bank. It consumes the five configuration bytes (output enables, PWM enables, duty cycle) and drives 16 registered output pins. Each pin is forced low, held high, or driven with a shared 8-bit PWM waveform. The PWM period is 256 × PRESCALE clocks.

## Interface
Parameters:
- PRESCALE, default 12: number of clk cycles per PWM count step. Legal range is ≥ 1. The default gives a period of 3072 clk, about 3.26 kHz at 10 MHz.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- en_reg_out_7_0  input  8  output enable for pins 7:0
- en_reg_out_15_8  input  8  output enable for pins 15:8
- en_reg_pwm_7_0  input  8  PWM-mode select for pins 7:0
- en_reg_pwm_15_8  input  8  PWM-mode select for pins 15:8
- pwm_duty_cycle  input  8  shared duty value (0–255)
- pwm_out  output  16  registered pin drive; bit i is pin i
- period_start  output  1  one-clk pulse on the first clock of every PWM period

## Operation
- **Prescaler.** pre_cnt counts 0 to PRESCALE−1 and wraps. tick = (pre_cnt == PRESCALE−1). When PRESCALE = 1, tick is constantly 1.
- **PWM counter.** pwm_cnt is 8 bits and increments on tick. It wraps 255 → 0 by natural modulo-256 arithmetic, with no extra state.
- **period_start.** Decoded from registers: period_start = (pwm_cnt == 0 && pre_cnt == 0). It is high exactly one clk per period, including the first clk after reset release.
- **Duty compare.** pwm_sig = (duty_eff == 8'hFF) ? 1 : (pwm_cnt < duty_eff). The comparison is unsigned.
  - duty 0 → constantly low.
  - duty 255 → constantly high (special-cased, not 255/256).
  - otherwise high for duty_eff × PRESCALE clk per period.
- **Per pin i.** The enables are the concatenations en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}.
  - en_out[i] = 0 → pin low, regardless of en_pwm[i].
  - en_out[i] = 1, en_pwm[i] = 0 → pin high.
  - en_out[i] = 1, en_pwm[i] = 1 → pin = pwm_sig.
- All 16 PWM pins share one counter and are phase-aligned.
- Enable inputs are sampled every clk; no shadowing is applied to them.
- **Reset (async assert).** pre_cnt = 0, pwm_cnt = 0, pwm_out = 16'h0000, duty shadow = 0.
  - While rst_n is low, period_start reads 1 (it decodes from the zeroed counters), but pwm_out stays 0.
  - Reset mid-period aborts the period immediately. The counters restart from 0 on release.

## Timing
- pwm_out is registered: a change on any input is visible on pwm_out one clk later, subject to the duty shadowing in Configuration.
- pwm_out[i] in cycle n+1 reflects pwm_cnt and pre_cnt as they stood in cycle n. The waveform is therefore delayed one clk relative to period_start; the high phase of pin i begins the clk after period_start.
- Counter advance: pwm_cnt changes on the clk edge at which tick = 1.
- If tick and a duty change arrive in the same cycle, the compare uses the pre-edge pwm_cnt and the currently effective duty.

## Configuration
Macro: PWM_SYNC_UPDATE_EN.
- **Defined.** A duty shadow register loads pwm_duty_cycle on every clk edge where period_start = 1.
  - duty_eff = period_start ? pwm_duty_cycle : duty_shadow. The bypass lets the first cycle of a period already use the new value.
  - Duty writes mid-period take effect at the next period boundary, so there are no runt or stretched pulses.
- **Undefined.** No shadow register is instantiated; duty_eff = pwm_duty_cycle directly. A duty change affects pwm_out one clk later, even mid-period.

## Test plan
- **Reset and static drive.** Reset, then en_out = 16'hFFFF, en_pwm = 0, duty = 8'h80 → pwm_out = 16'hFFFF from the second clk after release; 16'h0000 throughout reset.
- **50 % duty, PRESCALE = 12.** en_out = en_pwm = 16'h0001, duty = 128 → pin 0 high for 1536 clk and low for 1536 clk per 3072-clk period. period_start pulses every 3072 clk, and pin 0 rises 1 clk after each pulse.
- **Duty extremes.** Duty 0 → pin constantly 0. Duty 255 → pin constantly 1, no low glitch across the 255 → 0 wrap. Duty 1 → high exactly 12 clk per period.
- **Enable priority.** en_out = 16'h00F0, en_pwm = 16'hFF00, duty = 64 → pins 7:4 high, pins 15:8 low, all others low; nothing toggles.
- **Mid-period duty write.** Change duty 200 → 10 at pwm_cnt = 50.
  - With PWM_SYNC_UPDATE_EN: the current period stays high for 200 × 12 clk, the next period for 120 clk.
  - Without it: the pin falls 1 clk after the write.
- **Reset mid-operation.** Assert rst_n at pwm_cnt = 100 → pwm_out goes to 0 asynchronously. After release, period_start is high on the first clk, and with duty = 128 the waveform restarts from count 0.
